// File: rtl/pcie_phy_pkg.sv
// Shared receive-PHY definitions: COM alignment symbol, byte width, lock FSM states
// and a saturating increment helper.
package pcie_phy_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam logic [7:0]  COM_SYMBOL = 8'hBC;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      LOCKING = 2'd1,
      ACTIVE  = 2'd2
   } lock_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/com_aligner.sv
// Bit-level byte alignment: serial shift register, bit counter within the byte window
// and the SEARCH/LOCKING/ACTIVE lock FSM driven by COM detection.
module com_aligner
   import pcie_phy_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic              clk_32f,
   input  logic              reset,
   input  logic              data_in,
   output logic [BYTE_W-1:0] sr_next_o,
   output logic              boundary_o,
   output logic              lock_fail_o,
   output logic              active_o
);

   localparam logic [3:0] LOCK_CNT_C = LOCK_COUNT[3:0];

   lock_state_e       state_q, state_d;
   logic [BYTE_W-1:0] sr_q;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [3:0]        com_cnt_q, com_cnt_d;
   logic              is_com_s;
   logic              win_end_s;

   assign sr_next_o = {sr_q[BYTE_W-2:0], data_in};
   assign is_com_s  = (sr_next_o == COM_SYMBOL);
   assign win_end_s = (bit_cnt_q == 3'd7);

   // State and alignment registers
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state_q   <= SEARCH;
         sr_q      <= {BYTE_W{1'b0}};
         bit_cnt_q <= 3'd0;
         com_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_next_o;
         bit_cnt_q <= bit_cnt_d;
         com_cnt_q <= com_cnt_d;
      end
   end

   // Next-state: a failed window drops back to SEARCH without rechecking the same edge
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      com_cnt_d = com_cnt_q;
      case (state_q)
         SEARCH: begin
            bit_cnt_d = 3'd0;
            if (is_com_s) begin
               com_cnt_d = 4'd1;
               state_d   = (LOCK_CNT_C == 4'd1) ? ACTIVE : LOCKING;
            end else begin
               com_cnt_d = 4'd0;
            end
         end
         LOCKING: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (win_end_s) begin
               if (is_com_s) begin
                  com_cnt_d = com_cnt_q + 4'd1;
                  state_d   = ((com_cnt_q + 4'd1) == LOCK_CNT_C) ? ACTIVE : LOCKING;
               end else begin
                  com_cnt_d = 4'd0;
                  state_d   = SEARCH;
               end
            end else begin
               state_d = LOCKING;
            end
         end
         ACTIVE: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
         default: begin
            state_d   = SEARCH;
            bit_cnt_d = 3'd0;
            com_cnt_d = 4'd0;
         end
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      boundary_o  = (state_q == ACTIVE) && win_end_s;
      lock_fail_o = (state_q == LOCKING) && win_end_s && !is_com_s;
      active_o    = (state_q == ACTIVE);
   end

endmodule

// File: rtl/serial_parallel.sv
// Receive deserializer: COM-aligned byte recovery with strobe and idle reporting.
// Build option SP_RX_ERR_CNT_EN adds a saturating lock-failure counter on err_cnt.
module serial_parallel
   import pcie_phy_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic              clk_32f,
   input  logic              reset,
   input  logic              data_in,
   output logic [BYTE_W-1:0] data_out,
   output logic              valid_out,
   output logic              byte_strobe,
   output logic              active
`ifdef SP_RX_ERR_CNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   logic [BYTE_W-1:0] sr_next_s;
   logic              boundary_s;
   logic              lock_fail_s;
   logic              active_s;
   logic [BYTE_W-1:0] data_q;
   logic              valid_q;
   logic              strobe_q;

   com_aligner #(
      .LOCK_COUNT (LOCK_COUNT)
   ) u_aligner (
      .clk_32f     (clk_32f),
      .reset       (reset),
      .data_in     (data_in),
      .sr_next_o   (sr_next_s),
      .boundary_o  (boundary_s),
      .lock_fail_o (lock_fail_s),
      .active_o    (active_s)
   );

   // Byte output registers, loaded on the edge that samples each byte's last bit
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         data_q   <= {BYTE_W{1'b0}};
         valid_q  <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= boundary_s;
         if (boundary_s) begin
            data_q  <= sr_next_s;
            valid_q <= (sr_next_s != COM_SYMBOL);
         end else begin
            data_q  <= data_q;
            valid_q <= valid_q;
         end
      end
   end

   assign data_out    = data_q;
   assign valid_out   = valid_q;
   assign byte_strobe = strobe_q;
   assign active      = active_s;

`ifdef SP_RX_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   // Lock-failure counter, sticky at full scale until reset
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         err_cnt_q <= 8'h00;
      end else if (lock_fail_s) begin
         err_cnt_q <= sat_inc8(err_cnt_q);
      end else begin
         err_cnt_q <= err_cnt_q;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_lock_fail_s;
   assign unused_lock_fail_s = lock_fail_s;
`endif

endmodule

// File: tb/tb_serial_parallel.sv
// Self-checking bench for serial_parallel: table-driven byte checks, hand-written
// corner sequences and random streams compared against a time-indexed reference model.
module tb_serial_parallel;

   localparam logic [7:0] COM   = 8'hBC;
   localparam int         LOCKN = 4;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;
`ifdef SP_RX_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_32f = ~clk_32f;

   serial_parallel #(
      .LOCK_COUNT (LOCKN)
   ) dut (
      .clk_32f     (clk_32f),
      .reset       (reset),
      .data_in     (data_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .byte_strobe (byte_strobe),
      .active      (active)
`ifdef SP_RX_ERR_CNT_EN
      ,
      .err_cnt     (err_cnt)
`endif
   );

   typedef struct {
      logic [7:0] tx;
      logic [7:0] exp_data;
      logic       exp_valid;
   } vec_t;

   vec_t vecs[7];

   // Reference model: bit time index, last 8 bits as an integer, alignment anchor time
   int      m_win;
   bit      m_locked;
   int      m_run;
   longint  m_t;
   longint  m_anchor;
   int      m_data;
   bit      m_valid;
   bit      m_strobe;
   int      m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_win = 0; m_locked = 0; m_run = 0; m_t = 0; m_anchor = 0;
      m_data = 0; m_valid = 0; m_strobe = 0; m_err = 0;
   endtask

   task automatic model_step(input bit b);
      m_t++;
      m_win    = ((m_win << 1) | int'(b)) & 255;
      m_strobe = 0;
      if (m_locked) begin
         if ((m_t - m_anchor) % 8 == 0) begin
            m_strobe = 1;
            m_data   = m_win;
            m_valid  = (m_win != int'(COM));
         end
      end else if (m_run == 0) begin
         if (m_win == int'(COM)) begin
            m_run    = 1;
            m_anchor = m_t;
            if (LOCKN == 1) m_locked = 1;
         end
      end else if ((m_t - m_anchor) % 8 == 0) begin
         if (m_win == int'(COM)) begin
            m_run++;
            if (m_run == LOCKN) m_locked = 1;
         end else begin
            m_run = 0;
            m_err = (m_err < 255) ? m_err + 1 : 255;
         end
      end
   endtask

   task automatic send_bit(input bit b);
      @(negedge clk_32f);
      data_in = b;
      model_step(b);
      @(posedge clk_32f);
      #1;
      check("model_data",   32'(data_out),    32'(m_data));
      check("model_valid",  32'(valid_out),   32'(m_valid));
      check("model_strobe", 32'(byte_strobe), 32'(m_strobe));
      check("model_active", 32'(active),      32'(m_locked));
`ifdef SP_RX_ERR_CNT_EN
      check("model_err",    32'(err_cnt),     32'(m_err));
`endif
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_data"},   32'(data_out),    32'h0);
      check({tag, "_valid"},  32'(valid_out),   32'h0);
      check({tag, "_strobe"}, 32'(byte_strobe), 32'h0);
      check({tag, "_active"}, 32'(active),      32'h0);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk_32f);
      reset = 1'b0;
      data_in = 1'b0;
      model_reset();
      repeat (cycles) @(posedge clk_32f);
      #1;
      check_zero("reset");
`ifdef SP_RX_ERR_CNT_EN
      check("reset_err", 32'(err_cnt), 32'h0);
`endif
      @(negedge clk_32f);
      reset = 1'b1;
   endtask

   task automatic lock_and_table(input int first, input int last);
      for (int k = 0; k < 4; k++) begin
         send_byte(COM);
         check("lock_active", 32'(active), (k == 3) ? 32'h1 : 32'h0);
      end
      for (int i = first; i <= last; i++) begin
         send_byte(vecs[i].tx);
         check("tbl_strobe", 32'(byte_strobe), 32'h1);
         check("tbl_data",   32'(data_out),    32'(vecs[i].exp_data));
         check("tbl_valid",  32'(valid_out),   32'(vecs[i].exp_valid));
      end
   endtask

   initial begin
      vecs[0] = '{tx: 8'hAA, exp_data: 8'hAA, exp_valid: 1'b1};
      vecs[1] = '{tx: 8'hBB, exp_data: 8'hBB, exp_valid: 1'b1};
      vecs[2] = '{tx: 8'hCC, exp_data: 8'hCC, exp_valid: 1'b1};
      vecs[3] = '{tx: 8'hDD, exp_data: 8'hDD, exp_valid: 1'b1};
      vecs[4] = '{tx: 8'hFF, exp_data: 8'hFF, exp_valid: 1'b1};
      vecs[5] = '{tx: 8'hBC, exp_data: 8'hBC, exp_valid: 1'b0};
      vecs[6] = '{tx: 8'hAA, exp_data: 8'hAA, exp_valid: 1'b1};

      // Lock test, then idle test while still locked
      do_reset(16);
      lock_and_table(0, 3);
      for (int i = 4; i <= 6; i++) begin
         send_byte(vecs[i].tx);
         check("idle_strobe", 32'(byte_strobe), 32'h1);
         check("idle_data",   32'(data_out),    32'(vecs[i].exp_data));
         check("idle_valid",  32'(valid_out),   32'(vecs[i].exp_valid));
      end

      // Offset test: three junk bits shift every strobe by three clocks
      do_reset(4);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      lock_and_table(0, 3);

      // Failed lock
      do_reset(4);
      send_byte(COM); send_byte(COM); send_byte(COM); send_byte(8'h55);
      check("fail_active", 32'(active), 32'h0);
`ifdef SP_RX_ERR_CNT_EN
      check("fail_err", 32'(err_cnt), 32'h1);
`endif
      for (int i = 0; i < 16; i++) send_bit(1'b0);

      // Reset between two strobes in ACTIVE
      do_reset(4);
      send_byte(COM); send_byte(COM); send_byte(COM); send_byte(COM);
      send_byte(8'h12);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      check_zero("async_rst");
      repeat (3) @(posedge clk_32f);
      @(negedge clk_32f);
      reset = 1'b1;
      send_byte(COM); send_byte(COM); send_byte(COM); send_byte(COM);
      send_byte(8'hEA);
      check("post_rst_strobe", 32'(byte_strobe), 32'h1);
      check("post_rst_data",   32'(data_out),    32'hEA);
      check("post_rst_valid",  32'(valid_out),   32'h1);

      // Random streams: random junk prefix, lock, random payload mixed with COMs
      for (int r = 0; r < 6; r++) begin
         do_reset(2);
         for (int j = 0; j < int'($urandom_range(0, 7)); j++) send_bit(1'($urandom_range(0, 1)));
         for (int k = 0; k < 4; k++) send_byte(COM);
         for (int j = 0; j < 24; j++) begin
            if ($urandom_range(0, 4) == 0) send_byte(COM);
            else send_byte(8'($urandom_range(0, 255)));
         end
      end

      // Random bits without forced alignment: exercises false COMs and fallbacks
      do_reset(2);
      for (int j = 0; j < 400; j++) send_bit(1'($urandom_range(0, 1)));

`ifdef SP_RX_ERR_CNT_EN
      // Saturation: 300 failed lock attempts
      do_reset(2);
      for (int a = 0; a < 300; a++) begin
         send_byte(COM);
         send_byte(8'h00);
      end
      check("sat_err", 32'(err_cnt), 32'hFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_parallel.md
Name: serial_parallel

Overview:
Receive-side deserializer paired with the parallel_serial transmitter in the PHY layer. Samples a 1-bit serial stream on clk_32f, shifted MSB first, and finds the byte boundary by detecting the COM symbol. After LOCK_COUNT consecutive aligned COMs it declares lock and emits one byte per 8 clocks with a strobe. While locked, COM bytes are reported as idle (valid_out=0).

Parameters:
COM_SYMBOL, 8'hBC, alignment/idle symbol (the transmitter sends it when valid_in=0)
LOCK_COUNT, 4, consecutive boundary-aligned COMs needed to enter ACTIVE (range 1..15)

Ports:
clk_32f  input  1  serial bit clock; the only clock
reset  input  1  asynchronous, active-low reset
data_in  input  1  serial bit, sampled on posedge clk_32f, MSB of each byte first
data_out  output  8  last received byte; holds between strobes
valid_out  output  1  1 = data_out is payload (byte != COM_SYMBOL); 0 = idle/COM
byte_strobe  output  1  one-cycle pulse when data_out/valid_out update
active  output  1  1 while the FSM is in ACTIVE (aligned)

Behaviour:
- Reset (reset=0, async): state=SEARCH; shift register=0; bit_cnt=0; com_cnt=0; data_out=8'h00; valid_out=0; byte_strobe=0; active=0.
- Every clk_32f edge computes sr_next = {sr[6:0], data_in}. All decisions use sr_next.
- SEARCH: if sr_next==COM_SYMBOL, set bit_cnt=0 and com_cnt=1. Go to ACTIVE if LOCK_COUNT==1, otherwise to LOCKING. No strobes are produced in SEARCH.
- LOCKING: bit_cnt increments mod 8. At bit_cnt==7 (8th bit of a window):
  - if sr_next==COM_SYMBOL, com_cnt++. Go to ACTIVE when com_cnt+1==LOCK_COUNT.
  - otherwise go to SEARCH with com_cnt=0. The same edge does not re-check for COM.
- ACTIVE: bit_cnt increments mod 8. At bit_cnt==7: data_out<=sr_next; valid_out<=(sr_next!=COM_SYMBOL); byte_strobe=1 for exactly that cycle. The lock persists until reset.
- active<=1 is registered on the transition edge into ACTIVE. The first strobe arrives 8 clocks later, carrying the first byte after the locking COM.
- Latency: a byte's outputs update on the same edge that samples its 8th bit. Strobe period in ACTIVE is exactly 8 clk_32f cycles.
- Reset mid-operation: all state is lost immediately. After release the FSM restarts from SEARCH with no stale strobe.
- A COM pattern straddling a byte boundary in ACTIVE is ignored; no realignment.

Optional Feature:
SP_RX_ERR_CNT_EN
- Defined: adds output err_cnt[7:0]. It increments on each LOCKING->SEARCH fallback, saturates at 8'hFF, and is cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pcie_phy_pkg holds COM_SYMBOL (8'hBC), the FSM state enum {SEARCH, LOCKING, ACTIVE} as 2-bit localparams, and the byte width constant 8.
- One natural sub-module, com_aligner: shift register, bit_cnt and lock FSM, exporting sr_next, boundary and active. The top adds the output registers and the optional error counter.

Test Plan:
- Lock test: reset low 16 clocks, then serialize BC,BC,BC,BC,AA,BB,CC,DD MSB first. Required: active=1 after the 4th BC's last bit; strobes 8 clocks apart with data_out AA,BB,CC,DD and valid_out=1.
- Offset test: prepend 3 junk bits (101) before the sequence above. Required: identical output sequence, with every strobe time shifted by +3 clocks.
- Idle test: in ACTIVE send FF,BC,AA. Required: data_out FF/valid 1, then BC/valid 0, then AA/valid 1.
- Failed lock: send BC,BC,BC,55. Required: FSM back in SEARCH, active=0, no strobes. With SP_RX_ERR_CNT_EN, err_cnt=1.
- Reset mid-ACTIVE: assert reset between two strobes. Required: all outputs 0 asynchronously. After release, a fresh 4xBC + EA gives one strobe with EA, valid_out=1.
- Saturation (SP_RX_ERR_CNT_EN defined): 300 failed lock attempts. Required: err_cnt=8'hFF and no wrap.
